bisr_remap: RTL and testbench

Built-in self-repair remap stage placed between the BIST engine and the memory-controller datapath of MEMCTRL. During a BIST run it records up to NSPARE faulty word addresses in a spare-address register file. After the run it compares every functional access against that file and redirects hits to an on-block spare word array. This masks faulty SRAM cells from the host interface.

---
 rtl/bisr_remap.sv | 144 ++++++++++++++
 tb/tb_bisr_remap.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bisr_remap.sv
// Built-in self-repair remap: captures BIST failing addresses into spare entries, then redirects hits.
// Macro BISR_DUPCHK_EN enables the duplicate-address filter during capture.
module bisr_remap #(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 8,
  parameter int unsigned NSPARE = 8
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      BISR_EN,
  input  logic                      bist_start,
  input  logic                      bist_done,
  input  logic                      fail_vld,
  input  logic [AW-1:0]             fail_addr,
  input  logic                      clr,
  input  logic                      acc_vld,
  input  logic                      acc_we,
  input  logic [AW-1:0]             acc_addr,
  input  logic [DW-1:0]             acc_wdata,
  output logic                      acc_hit,
  output logic [DW-1:0]             acc_rdata,
  output logic [$clog2(NSPARE):0]   repair_cnt,
  output logic                      repair_ovf,
  output logic                      repair_ok
);

  localparam int unsigned IW = $clog2(NSPARE);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, LOCKED, FAIL} state_t;

  state_t            state, state_next;
  logic [AW-1:0]     addr_q  [NSPARE];
  logic [DW-1:0]     data_q  [NSPARE];
  logic [NSPARE-1:0] valid_q;

  logic          dup_hit;
  logic          full;
  logic          fail_take;
  logic          alloc;
  logic          ovf_set;
  logic          ovf_next;
  logic          clear_all;
  logic          lk_vld;
  logic          lk_match;
  logic [IW-1:0] lk_idx;
  logic [IW-1:0] cnt_idx;

  // Capture qualification and duplicate filter
  always_comb begin
    dup_hit = 1'b0;
`ifdef BISR_DUPCHK_EN
    for (int unsigned i = 0; i < NSPARE; i++) begin
      if (valid_q[i] && (addr_q[i] == fail_addr)) dup_hit = 1'b1;
    end
`endif
    full      = (repair_cnt == CW'(NSPARE));
    clear_all = clr || (BISR_EN && bist_start && ((state == IDLE) || (state == COLLECT)));
    fail_take = BISR_EN && (state == COLLECT) && fail_vld && !clr && !bist_start;
    alloc     = fail_take && !dup_hit && !full;
    ovf_set   = fail_take && !dup_hit && full;
    ovf_next  = repair_ovf || ovf_set;
    cnt_idx   = repair_cnt[IW-1:0];
  end

  // Parallel lookup; lowest matching index wins
  always_comb begin
    lk_match = 1'b0;
    lk_idx   = '0;
    for (int unsigned i = 0; i < NSPARE; i++) begin
      if (!lk_match && valid_q[i] && (addr_q[i] == acc_addr)) begin
        lk_match = 1'b1;
        lk_idx   = IW'(i);
      end
    end
    lk_vld = BISR_EN && (state == LOCKED) && acc_vld && !clr;
  end

  always_comb begin
    state_next = state;
    if (clr) begin
      state_next = IDLE;
    end else if (BISR_EN) begin
      case (state)
        IDLE:    if (bist_start) state_next = COLLECT;
        COLLECT: begin
          if (bist_start)     state_next = COLLECT;
          else if (bist_done) state_next = ovf_next ? FAIL : LOCKED;
        end
        LOCKED:  state_next = LOCKED;
        FAIL:    state_next = FAIL;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      repair_ok <= 1'b0;
    end else begin
      state     <= state_next;
      repair_ok <= (state_next == LOCKED);
    end
  end

  // Spare register file, counters and registered lookup results
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      valid_q    <= '0;
      repair_cnt <= '0;
      repair_ovf <= 1'b0;
      acc_hit    <= 1'b0;
      acc_rdata  <= '0;
      for (int unsigned i = 0; i < NSPARE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (clear_all) begin
      valid_q    <= '0;
      repair_cnt <= '0;
      repair_ovf <= 1'b0;
      acc_hit    <= 1'b0;
      for (int unsigned i = 0; i < NSPARE; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      acc_hit <= lk_vld && lk_match;
      if (alloc) begin
        addr_q[cnt_idx]  <= fail_addr;
        data_q[cnt_idx]  <= '0;
        valid_q[cnt_idx] <= 1'b1;
        repair_cnt       <= repair_cnt + CW'(1);
      end
      if (ovf_set) repair_ovf <= 1'b1;
      if (lk_vld && lk_match) begin
        if (acc_we) data_q[lk_idx] <= acc_wdata;
        else        acc_rdata      <= data_q[lk_idx];
      end
    end
  end

endmodule

// File: tb/tb_bisr_remap.sv
// Directed bench for bisr_remap: capture, redirect, duplicates, overflow, clear/enable, reset.
module tb_bisr_remap;

  logic        CLK = 1'b0;
  logic        RSTN, BISR_EN, bist_start, bist_done, fail_vld, clr;
  logic        acc_vld, acc_we;
  logic [15:0] fail_addr, acc_addr;
  logic [7:0]  acc_wdata;
  logic        acc_hit, repair_ovf, repair_ok;
  logic [7:0]  acc_rdata;
  logic [3:0]  repair_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  bisr_remap dut (
    .CLK(CLK), .RSTN(RSTN), .BISR_EN(BISR_EN),
    .bist_start(bist_start), .bist_done(bist_done),
    .fail_vld(fail_vld), .fail_addr(fail_addr), .clr(clr),
    .acc_vld(acc_vld), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_hit(acc_hit), .acc_rdata(acc_rdata),
    .repair_cnt(repair_cnt), .repair_ovf(repair_ovf), .repair_ok(repair_ok)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    BISR_EN = 1'b1; bist_start = 1'b0; bist_done = 1'b0; fail_vld = 1'b0;
    clr = 1'b0; acc_vld = 1'b0; acc_we = 1'b0;
    fail_addr = '0; acc_addr = '0; acc_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RSTN = 1'b0;
    repeat (3) step();
    RSTN = 1'b1;
  endtask

  task automatic start_run();
    bist_start = 1'b1; step(); bist_start = 1'b0;
  endtask

  task automatic fail_at(input logic [15:0] a);
    fail_vld = 1'b1; fail_addr = a; step(); fail_vld = 1'b0;
  endtask

  task automatic end_run();
    bist_done = 1'b1; step(); bist_done = 1'b0; step();
  endtask

  task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d);
    acc_vld = 1'b1; acc_we = we; acc_addr = a; acc_wdata = d;
    step();
    acc_vld = 1'b0; acc_we = 1'b0;
  endtask

  task automatic capture_run();
    do_reset();
    start_run();
    fail_at(16'h0400);
    fail_at(16'h05A0);
    end_run();
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if ({acc_hit, repair_ovf, repair_ok} !== 3'b000) begin miscompares++;
      $display("FAIL rst_flags: got %b exp 000", {acc_hit, repair_ovf, repair_ok}); end
    vectors++; if (repair_cnt !== 4'd0) begin miscompares++;
      $display("FAIL rst_cnt: got %0d exp 0", repair_cnt); end
    vectors++; if (acc_rdata !== 8'h00) begin miscompares++;
      $display("FAIL rst_rdata: got %h exp 00", acc_rdata); end
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL idle_nohit: got %b exp 0", acc_hit); end
  endtask

  task automatic test_capture();
    capture_run();
    vectors++; if (repair_cnt !== 4'd2) begin miscompares++;
      $display("FAIL cap_cnt: got %0d exp 2", repair_cnt); end
    vectors++; if ({repair_ok, repair_ovf} !== 2'b10) begin miscompares++;
      $display("FAIL cap_ok_ovf: got %b exp 10", {repair_ok, repair_ovf}); end
    access(1'b1, 16'h0400, 8'h5A);
    vectors++; if (acc_hit !== 1'b1) begin miscompares++;
      $display("FAIL cap_whit: got %b exp 1", acc_hit); end
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if ({acc_hit, acc_rdata} !== {1'b1, 8'h5A}) begin miscompares++;
      $display("FAIL cap_rd: got %b/%h exp 1/5a", acc_hit, acc_rdata); end
    access(1'b0, 16'h0002, 8'h00);
    vectors++; if ({acc_hit, acc_rdata} !== {1'b0, 8'h5A}) begin miscompares++;
      $display("FAIL cap_miss: got %b/%h exp 0/5a", acc_hit, acc_rdata); end
    access(1'b0, 16'h05A0, 8'h00);
    vectors++; if ({acc_hit, acc_rdata} !== {1'b1, 8'h00}) begin miscompares++;
      $display("FAIL cap_fresh: got %b/%h exp 1/00", acc_hit, acc_rdata); end
  endtask

  task automatic test_back_to_back();
    capture_run();
    access(1'b1, 16'h05A0, 8'h33);
    access(1'b0, 16'h05A0, 8'h00);
    vectors++; if ({acc_hit, acc_rdata} !== {1'b1, 8'h33}) begin miscompares++;
      $display("FAIL b2b_wr_rd: got %b/%h exp 1/33", acc_hit, acc_rdata); end
    step();
    vectors++; if ({acc_hit, acc_rdata} !== {1'b0, 8'h33}) begin miscompares++;
      $display("FAIL b2b_hold: got %b/%h exp 0/33", acc_hit, acc_rdata); end
  endtask

  task automatic test_dup();
    logic [3:0] exp_cnt;
`ifdef BISR_DUPCHK_EN
    exp_cnt = 4'd1;
`else
    exp_cnt = 4'd3;
`endif
    do_reset();
    start_run();
    fail_vld = 1'b1; fail_addr = 16'h0400;
    repeat (3) step();
    fail_vld = 1'b0;
    end_run();
    vectors++; if (repair_cnt !== exp_cnt) begin miscompares++;
      $display("FAIL dup_cnt: got %0d exp %0d", repair_cnt, exp_cnt); end
    access(1'b1, 16'h0400, 8'hC3);
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if ({acc_hit, acc_rdata} !== {1'b1, 8'hC3}) begin miscompares++;
      $display("FAIL dup_rd: got %b/%h exp 1/c3", acc_hit, acc_rdata); end
  endtask

  task automatic test_overflow();
    do_reset();
    start_run();
    for (int i = 0; i < 9; i++) fail_at(16'h0100 + 16'(i));
    vectors++; if ({repair_cnt, repair_ovf} !== {4'd8, 1'b1}) begin miscompares++;
      $display("FAIL ovf_sat: got %0d/%b exp 8/1", repair_cnt, repair_ovf); end
    end_run();
    vectors++; if (repair_ok !== 1'b0) begin miscompares++;
      $display("FAIL ovf_ok: got %b exp 0", repair_ok); end
    access(1'b0, 16'h0100, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL ovf_nohit: got %b exp 0", acc_hit); end
    clr = 1'b1; step(); clr = 1'b0;
    vectors++; if ({repair_cnt, repair_ovf} !== {4'd0, 1'b0}) begin miscompares++;
      $display("FAIL ovf_clr: got %0d/%b exp 0/0", repair_cnt, repair_ovf); end
  endtask

  task automatic test_done_with_fail();
    do_reset();
    start_run();
    for (int i = 0; i < 8; i++) fail_at(16'h0200 + 16'(i));
    fail_vld = 1'b1; fail_addr = 16'h0208; bist_done = 1'b1;
    step();
    fail_vld = 1'b0; bist_done = 1'b0;
    step();
    vectors++; if ({repair_ovf, repair_ok} !== 2'b10) begin miscompares++;
      $display("FAIL dwf_exit: got %b exp 10", {repair_ovf, repair_ok}); end
    do_reset();
    start_run();
    fail_vld = 1'b1; fail_addr = 16'h0300; bist_done = 1'b1;
    step();
    fail_vld = 1'b0; bist_done = 1'b0;
    step();
    vectors++; if ({repair_cnt, repair_ok} !== {4'd1, 1'b1}) begin miscompares++;
      $display("FAIL dwf_lock: got %0d/%b exp 1/1", repair_cnt, repair_ok); end
  endtask

  task automatic test_clear();
    capture_run();
    clr = 1'b1; step(); clr = 1'b0;
    vectors++; if ({repair_cnt, repair_ok} !== {4'd0, 1'b0}) begin miscompares++;
      $display("FAIL clr_state: got %0d/%b exp 0/0", repair_cnt, repair_ok); end
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL clr_nohit: got %b exp 0", acc_hit); end
  endtask

  task automatic test_enable();
    capture_run();
    BISR_EN = 1'b0;
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL en_off: got %b exp 0", acc_hit); end
    BISR_EN = 1'b1;
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if ({acc_hit, repair_cnt} !== {1'b1, 4'd2}) begin miscompares++;
      $display("FAIL en_on: got %b/%0d exp 1/2", acc_hit, repair_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_run();
    fail_at(16'h0400);
    fail_at(16'h05A0);
    vectors++; if (repair_cnt !== 4'd2) begin miscompares++;
      $display("FAIL mid_pre: got %0d exp 2", repair_cnt); end
    RSTN = 1'b0; step(); RSTN = 1'b1;
    vectors++; if (repair_cnt !== 4'd0) begin miscompares++;
      $display("FAIL mid_rst: got %0d exp 0", repair_cnt); end
    start_run();
    fail_at(16'h0777);
    end_run();
    vectors++; if (repair_cnt !== 4'd1) begin miscompares++;
      $display("FAIL mid_run: got %0d exp 1", repair_cnt); end
    access(1'b0, 16'h0400, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL mid_old: got %b exp 0", acc_hit); end
  endtask

  task automatic test_restart();
    do_reset();
    start_run();
    fail_at(16'h0A00);
    fail_at(16'h0A01);
    start_run();
    fail_at(16'h0B00);
    end_run();
    vectors++; if (repair_cnt !== 4'd1) begin miscompares++;
      $display("FAIL rs_cnt: got %0d exp 1", repair_cnt); end
    access(1'b0, 16'h0A00, 8'h00);
    vectors++; if (acc_hit !== 1'b0) begin miscompares++;
      $display("FAIL rs_old: got %b exp 0", acc_hit); end
    access(1'b0, 16'h0B00, 8'h00);
    vectors++; if (acc_hit !== 1'b1) begin miscompares++;
      $display("FAIL rs_new: got %b exp 1", acc_hit); end
  endtask

  initial begin
    RSTN = 1'b0;
    idle_inputs();
    test_reset();
    test_capture();
    test_back_to_back();
    test_dup();
    test_overflow();
    test_done_with_fail();
    test_clear();
    test_enable();
    test_reset_mid();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
